div_fp16_multicycle: RTL and testbench

Iterative IEEE-754 binary16 divider with a start/done handshake matching the FP16 multiply unit, so issue logic drives both units the same way. It computes result = a / b using a radix-2 restoring mantissa divider, one quotient bit per cycle. Rounding is round-to-nearest-even. Subnormal inputs and outputs are flushed to zero. The block sits beside the FP16 multiplier in the vector/scalar FP execute path.

---
 rtl/div_fp16_multicycle.sv | 149 ++++++++++++++
 tb/tb_div_fp16_multicycle.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/div_fp16_multicycle.sv
// Iterative FP16 divider: radix-2 restoring mantissa division, one quotient bit per cycle,
// round-to-nearest-even, subnormals flushed to zero. start/done handshake shared with the FP16 multiplier.
module div_fp16_multicycle (
   input  logic        clk,
   input  logic        nRST,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] result,
   output logic        done,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, SPEC, DIV, ROUND} state_t;

   state_t             state, next_state;
   logic [14:0]        a_q, b_q;
   logic               sign_q;
   logic [11:0]        rem_q;
   logic [10:0]        den_q;
   logic [12:0]        quo_q;
   logic [3:0]         iter_q;
   logic signed [6:0]  exp_q;

   function automatic logic is_zero(input logic [14:0] x);
      return x[14:10] == 5'd0;
   endfunction

   function automatic logic is_inf(input logic [14:0] x);
      return (x[14:10] == 5'd31) && (x[9:0] == 10'd0);
   endfunction

   function automatic logic is_nan(input logic [14:0] x);
      return (x[14:10] == 5'd31) && (x[9:0] != 10'd0);
   endfunction

   function automatic logic [15:0] spec_result(input logic [14:0] x, input logic [14:0] y,
                                               input logic sgn);
      if (is_nan(x) || is_nan(y) || (is_inf(x) && is_inf(y)) || (is_zero(x) && is_zero(y)))
         return 16'h7E00;
      else if (is_inf(x) || is_zero(y))
         return {sgn, 15'h7C00};
      else
         return {sgn, 15'h0000};
   endfunction

   // Normalize, round to nearest even, then saturate to inf or flush to zero.
   function automatic logic [15:0] round_pack(input logic [12:0] quo, input logic [11:0] rem,
                                              input logic signed [6:0] ex, input logic sgn);
      logic [9:0]        mant;
      logic              g, s, rnd;
      logic [10:0]       sum;
      logic signed [6:0] e;
      if (quo[12]) begin
         mant = quo[11:2];
         g    = quo[1];
         s    = quo[0] | (rem != 12'd0);
         e    = ex;
      end else begin
         mant = quo[10:1];
         g    = quo[0];
         s    = (rem != 12'd0);
         e    = ex - 7'sd1;
      end
      rnd  = g & (s | mant[0]);
      sum  = {1'b0, mant} + {10'd0, rnd};
      mant = sum[9:0];
      if (sum[10])
         e = e + 7'sd1;
      if (e >= 7'sd31)
         return {sgn, 15'h7C00};
      else if (e <= 7'sd0)
         return {sgn, 15'h0000};
      else
         return {sgn, e[4:0], mant};
   endfunction

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (start)
                   next_state = (is_zero(a[14:0]) || is_zero(b[14:0]) ||
                                 a[14:10] == 5'd31 || b[14:10] == 5'd31) ? SPEC : DIV;
         SPEC:  next_state = IDLE;
         DIV:   if (iter_q == 4'd12) next_state = ROUND;
         ROUND: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         a_q    <= '0;
         b_q    <= '0;
         sign_q <= 1'b0;
         rem_q  <= '0;
         den_q  <= '0;
         quo_q  <= '0;
         iter_q <= '0;
         exp_q  <= '0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               a_q    <= a[14:0];
               b_q    <= b[14:0];
               sign_q <= a[15] ^ b[15];
               rem_q  <= {2'b01, a[9:0]};
               den_q  <= {1'b1, b[9:0]};
               quo_q  <= '0;
               iter_q <= '0;
               exp_q  <= $signed({2'b00, a[14:10]}) - $signed({2'b00, b[14:10]}) + 7'sd15;
            end
            SPEC: begin
               result <= spec_result(a_q, b_q, sign_q);
               done   <= 1'b1;
            end
            DIV: begin
               // Remainder stays below the divisor, so the shift never overflows 12 bits.
               if (rem_q >= {1'b0, den_q}) begin
                  rem_q <= (rem_q - {1'b0, den_q}) << 1;
                  quo_q <= {quo_q[11:0], 1'b1};
               end else begin
                  rem_q <= rem_q << 1;
                  quo_q <= {quo_q[11:0], 1'b0};
               end
               iter_q <= iter_q + 4'd1;
            end
            ROUND: begin
               result <= round_pack(quo_q, rem_q, exp_q, sign_q);
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_fp16_multicycle.sv
// Directed-vector bench for div_fp16_multicycle: results, latency, handshake and reset.
module tb_div_fp16_multicycle;

   localparam int LAT_SPEC = 2;   // negedges after the accepting edge until done is seen
   localparam int LAT_NORM = 15;
   localparam int MAX_WAIT = 40;

   logic        clk = 1'b0;
   logic        nRST = 1'b0;
   logic        start = 1'b0;
   logic [15:0] a_in = '0;
   logic [15:0] b_in = '0;
   logic [15:0] result;
   logic        done;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   div_fp16_multicycle dut (
      .clk    (clk),
      .nRST   (nRST),
      .start  (start),
      .a      (a_in),
      .b      (b_in),
      .result (result),
      .done   (done),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the first negedge after the accepting edge.
   task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v);
      a_in  = ta;
      b_in  = tb_v;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a_in  = 16'hFFFF;
      b_in  = 16'hFFFF;
   endtask

   task automatic wait_done(inout int lat);
      while (!done && lat < MAX_WAIT) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic [15:0] exp_res, input int exp_lat);
      int lat;
      issue(ta, tb_v);
      lat = 1;
      wait_done(lat);
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " result"}, result, exp_res);
      check({tag, " busy in done cycle"}, busy, 1'b0);
      @(negedge clk);
      check({tag, " done width"}, done, 1'b0);
   endtask

   initial begin
      int lat;
      int ndone;
      logic [15:0] held;

      repeat (2) @(negedge clk);
      check("reset result", result, 16'h0000);
      check("reset done", done, 1'b0);
      check("reset busy", busy, 1'b0);
      nRST = 1'b1;
      @(negedge clk);

      run_op("3/2",        16'h4200, 16'h4000, 16'h3E00, LAT_NORM);
      run_op("-3/2",       16'hC200, 16'h4000, 16'hBE00, LAT_NORM);
      run_op("1/3",        16'h3C00, 16'h4200, 16'h3555, LAT_NORM);
      run_op("1/0",        16'h3C00, 16'h0000, 16'h7C00, LAT_SPEC);
      run_op("0/0",        16'h0000, 16'h0000, 16'h7E00, LAT_SPEC);
      run_op("inf/inf",    16'h7C00, 16'h7C00, 16'h7E00, LAT_SPEC);
      run_op("2/inf",      16'h4000, 16'h7C00, 16'h0000, LAT_SPEC);
      run_op("nan/1",      16'h7E01, 16'h3C00, 16'h7E00, LAT_SPEC);
      run_op("subnorm/1",  16'h0001, 16'h3C00, 16'h0000, LAT_SPEC);
      run_op("-1/0",       16'hBC00, 16'h0000, 16'hFC00, LAT_SPEC);
      run_op("overflow",   16'h7BFF, 16'h0400, 16'h7C00, LAT_NORM);
      run_op("underflow",  16'h0400, 16'h7BFF, 16'h0000, LAT_NORM);
      run_op("exact",      16'h3FFF, 16'h3C00, 16'h3FFF, LAT_NORM);

      held = result;
      repeat (5) @(negedge clk);
      check("result hold", result, held);

      // Start pulsed mid-division must neither relatch nor add a done.
      issue(16'h4200, 16'h4000);
      lat = 1;
      repeat (4) begin @(negedge clk); lat++; end
      a_in  = 16'h3C00;
      b_in  = 16'h4200;
      start = 1'b1;
      @(negedge clk); lat++;
      start = 1'b0;
      wait_done(lat);
      check("busy-start latency", lat, LAT_NORM);
      check("busy-start result", result, 16'h3E00);
      ndone = 0;
      repeat (20) begin @(negedge clk); if (done) ndone++; end
      check("busy-start extra done", ndone, 0);

      // Back-to-back: second start issued in the done cycle of the first.
      issue(16'h3C00, 16'h4200);
      lat = 1;
      wait_done(lat);
      check("b2b first latency", lat, LAT_NORM);
      check("b2b first result", result, 16'h3555);
      issue(16'hC200, 16'h4000);
      lat = 1;
      wait_done(lat);
      check("b2b second latency", lat, LAT_NORM);
      check("b2b second result", result, 16'hBE00);
      @(negedge clk);

      // Reset around the sixth division iteration drops the operation.
      issue(16'h3C00, 16'h4200);
      repeat (5) @(negedge clk);
      nRST = 1'b0;
      #1;
      check("mid reset result", result, 16'h0000);
      check("mid reset busy", busy, 1'b0);
      check("mid reset done", done, 1'b0);
      @(negedge clk);
      nRST = 1'b1;
      ndone = 0;
      repeat (20) begin @(negedge clk); if (done) ndone++; end
      check("post reset no done", ndone, 0);
      run_op("after reset", 16'h4200, 16'h4000, 16'h3E00, LAT_NORM);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
